seq_multiplier: RTL



---
 rtl/seq_multiplier.sv | 118 +++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential unsigned shift-and-add multiplier
// One add-and-shift iteration per clock; product held until the next completion.

module add_sub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);
  logic [W:0] full;

  assign full    = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {{W{1'b0}}, sub_i};
  assign sum_o   = full[W-1:0];
  assign carry_o = full[W];
endmodule

module seq_multiplier #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(WIDTH - 1);

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     add_sum;
  logic                 add_carry;
  logic [WIDTH:0]       step_sum;
  logic [WIDTH-1:0]     acc_step;
  logic [WIDTH-1:0]     mplier_step;

  add_sub #(.W(WIDTH)) u_add_sub (
    .a_i     (acc_q),
    .b_i     (mcand_q),
    .sub_i   (1'b0),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // The adder carry becomes the top accumulator bit after the shift.
  always_comb begin
    step_sum                = mplier_q[0] ? {add_carry, add_sum} : {1'b0, acc_q};
    {acc_step, mplier_step} = {step_sum, mplier_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mcand_d  = a_i;
          mplier_d = b_i;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mplier_d = mplier_step;
        count_d  = count_q + CNT_WIDTH'(1);
        if (count_q == LAST) begin
          product_d = {acc_step, mplier_step};
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy_o    = (state_q == RUN);
  assign done_o    = (state_q == DONE);
  assign product_o = product_q;
endmodule
